// File: rtl/dds_phase_acc.sv
// dds_phase_acc
//   Phase-accumulator stage feeding the waveform ROM. Holds a frequency
//   tuning word (FTW) that is stepped up/down by active-low front-panel keys
//   while the system is in frequency mode. Each clock the accumulator
//   advances by the FTW. The top ADDR_W bits plus a phase offset form the
//   registered ROM address. A one-cycle sync pulse marks every accumulator
//   wrap.
//
// Ports
//   clk_i        system clock
//   clk_en_i     asynchronous active-low reset
//   FSM_state    system mode; FTW/step keys act only in FREQMODE (3'b010)
//   nkey_up      raw active-low key, raises FTW by the current step
//   nkey_down    raw active-low key, lowers FTW by the current step
//   nkey_step    raw active-low key, cycles the step index 0..3
//   phase_off_i  phase offset added to the ROM address
//   addr_o       registered ROM address
//   ftw_o        current frequency tuning word
//   step_idx_o   current step index (step = STEP_BASE << 2*step_idx)
//   sync_o       one-cycle pulse, aligned with the first post-wrap address
module dds_phase_acc #(
    parameter int unsigned          ACC_W       = 32,
    parameter int unsigned          ADDR_W      = 11,
    parameter logic [ACC_W-1:0]     FTW_DEFAULT = 32'd2097152,
    parameter logic [ACC_W-1:0]     FTW_MIN     = 32'd65536,
    parameter logic [ACC_W-1:0]     FTW_MAX     = 32'h4000_0000,
    parameter logic [ACC_W-1:0]     STEP_BASE   = 32'd65536
) (
    input  logic              clk_i,
    input  logic              clk_en_i,
    input  logic [2:0]        FSM_state,
    input  logic              nkey_up,
    input  logic              nkey_down,
    input  logic              nkey_step,
    input  logic [ADDR_W-1:0] phase_off_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ACC_W-1:0]  ftw_o,
    output logic [1:0]        step_idx_o,
    output logic              sync_o
);

    localparam logic [2:0] FREQMODE = 3'b010;

    // 2^(ACC_W-1), expressed in ACC_W+1 bits for the range check below.
    localparam logic [ACC_W:0] ACC_HALF = (ACC_W + 1)'(1) << (ACC_W - 1);

    // The saturating arithmetic relies on FTW_MAX staying below half the
    // accumulator range and on the default lying inside the limits.
    if ((FTW_MIN > FTW_DEFAULT) || (FTW_DEFAULT > FTW_MAX) ||
        ({1'b0, FTW_MAX} >= ACC_HALF) || (ADDR_W > ACC_W)) begin : g_bad_params
        $error("dds_phase_acc: FTW parameters out of range");
    end

    // Key bit order: [0]=up, [1]=down, [2]=step.
    logic [2:0] key_raw;
    logic [2:0] key_meta_q, key_meta_d;
    logic [2:0] key_sync_q, key_sync_d;
    logic [2:0] key_prev_q, key_prev_d;
    logic [2:0] key_ev;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sync_q, sync_d;
    logic [ACC_W-1:0]  ftw_q, ftw_d;
    logic [1:0]        step_idx_q, step_idx_d;

    logic              freq_mode;
    logic [ACC_W:0]    step_amt;
    logic [ACC_W:0]    up_sum;
    logic [ACC_W:0]    down_diff;
    logic [ACC_W-1:0]  up_sat;
    logic [ACC_W-1:0]  down_sat;

    assign key_raw = {nkey_step, nkey_down, nkey_up};

    // Key path: two-flop synchroniser then a previous-value flop; an event
    // is the cycle where the synchronised key has just gone low.
    always_comb begin
        key_meta_d = key_raw;
        key_sync_d = key_meta_q;
        key_prev_d = key_sync_q;
        key_ev     = ~key_sync_q & key_prev_q;
    end

    // FTW arithmetic is done one bit wider than the accumulator so neither
    // the up-sum nor the down-difference can wrap before saturation.
    always_comb begin
        freq_mode = (FSM_state == FREQMODE);
        step_amt  = {1'b0, STEP_BASE} << {step_idx_q, 1'b0};
        up_sum    = {1'b0, ftw_q} + step_amt;
        down_diff = {1'b0, ftw_q} - step_amt;

        if (up_sum > {1'b0, FTW_MAX}) begin
            up_sat = FTW_MAX;
        end else begin
            up_sat = up_sum[ACC_W-1:0];
        end

        // Top bit set means the subtraction borrowed (ftw < step).
        if (down_diff[ACC_W] || (down_diff[ACC_W-1:0] < FTW_MIN)) begin
            down_sat = FTW_MIN;
        end else begin
            down_sat = down_diff[ACC_W-1:0];
        end
    end

    // FTW / step index update. Events outside FREQMODE are simply dropped.
    // A step event alongside up/down uses the old step for the FTW change.
    always_comb begin
        ftw_d      = ftw_q;
        step_idx_d = step_idx_q;
        if (freq_mode) begin
            if (key_ev[0] && !key_ev[1]) begin
                ftw_d = up_sat;
            end else if (key_ev[1] && !key_ev[0]) begin
                ftw_d = down_sat;
            end
            if (key_ev[2]) begin
                step_idx_d = step_idx_q + 2'd1;
            end
        end
    end

    // Accumulator datapath. The address is taken from the pre-update
    // accumulator, so it trails acc by one edge; sync is the registered
    // carry, which lines it up with the first post-wrap address.
    always_comb begin
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw_q};
        addr_d           = acc_q[ACC_W-1 -: ADDR_W] + phase_off_i;
        sync_d           = carry_q;
    end

    always_ff @(posedge clk_i or negedge clk_en_i) begin
        if (!clk_en_i) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            key_prev_q <= '1;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            addr_q     <= '0;
            sync_q     <= 1'b0;
            ftw_q      <= FTW_DEFAULT;
            step_idx_q <= '0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_prev_q <= key_prev_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            addr_q     <= addr_d;
            sync_q     <= sync_d;
            ftw_q      <= ftw_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign addr_o     = addr_q;
    assign ftw_o      = ftw_q;
    assign step_idx_o = step_idx_q;
    assign sync_o     = sync_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Testbench for dds_phase_acc: directed scenarios plus randomized key/mode/
// phase stimulus, all checked against a behavioural model of the phase
// accumulator, key edge detection and FTW saturation rules.
module tb_dds_phase_acc;

    localparam longint FTW_DEF = 2097152;
    localparam longint FTW_MIN = 65536;
    localparam longint FTW_MAX = 64'h4000_0000;
    localparam longint TWO32   = 64'h1_0000_0000;

    logic        clk_i = 1'b0;
    logic        clk_en_i;
    logic [2:0]  FSM_state;
    logic        nkey_up;
    logic        nkey_down;
    logic        nkey_step;
    logic [10:0] phase_off_i;
    logic [10:0] addr_o;
    logic [31:0] ftw_o;
    logic [1:0]  step_idx_o;
    logic        sync_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    longint m_acc;
    longint m_ftw;
    int     m_step;
    int     m_addr;
    bit     m_carry;
    bit     m_sync;
    bit     m_prev [3];
    bit     m_d0   [3];
    bit     m_d1   [3];

    always #5 clk_i = ~clk_i;

    dds_phase_acc #(
        .ACC_W       (32),
        .ADDR_W      (11),
        .FTW_DEFAULT (32'd2097152),
        .FTW_MIN     (32'd65536),
        .FTW_MAX     (32'h4000_0000),
        .STEP_BASE   (32'd65536)
    ) dut (
        .clk_i       (clk_i),
        .clk_en_i    (clk_en_i),
        .FSM_state   (FSM_state),
        .nkey_up     (nkey_up),
        .nkey_down   (nkey_down),
        .nkey_step   (nkey_step),
        .phase_off_i (phase_off_i),
        .addr_o      (addr_o),
        .ftw_o       (ftw_o),
        .step_idx_o  (step_idx_o),
        .sync_o      (sync_o)
    );

    task automatic m_reset();
        m_acc   = 0;
        m_ftw   = FTW_DEF;
        m_step  = 0;
        m_addr  = 0;
        m_carry = 0;
        m_sync  = 0;
        for (int k = 0; k < 3; k++) begin
            m_prev[k] = 1'b1;
            m_d0[k]   = 1'b0;
            m_d1[k]   = 1'b0;
        end
    endtask

    // Advance one clock and step the model with the inputs seen at the edge.
    // A key press is a 1->0 change in the sampled key; its effect lands two
    // edges after the edge that first sampled it low.
    task automatic tick();
        bit     raw [3];
        bit     ev  [3];
        longint sum;
        longint stp;
        @(posedge clk_i);
        if (!clk_en_i) begin
            m_reset();
        end else begin
            raw[0] = nkey_up;
            raw[1] = nkey_down;
            raw[2] = nkey_step;
            sum     = m_acc + m_ftw;
            m_addr  = int'(((m_acc / 2097152) + longint'(phase_off_i)) % 2048);
            m_sync  = m_carry;
            m_carry = (sum >= TWO32);
            m_acc   = sum % TWO32;
            for (int k = 0; k < 3; k++) begin
                ev[k]     = m_d1[k];
                m_d1[k]   = m_d0[k];
                m_d0[k]   = (raw[k] == 1'b0) && m_prev[k];
                m_prev[k] = raw[k];
            end
            if (FSM_state == 3'b010) begin
                stp = 65536 * (4 ** m_step);
                if (ev[0] && !ev[1]) begin
                    m_ftw = (m_ftw + stp > FTW_MAX) ? FTW_MAX : m_ftw + stp;
                end else if (ev[1] && !ev[0]) begin
                    m_ftw = (m_ftw - stp < FTW_MIN) ? FTW_MIN : m_ftw - stp;
                end
                if (ev[2]) m_step = (m_step + 1) % 4;
            end
        end
        #1;
    endtask

    // key: 0=up 1=down 2=step 3=up+down together
    task automatic press(input int key, input int hold);
        if (key == 0 || key == 3) nkey_up   = 1'b0;
        if (key == 1 || key == 3) nkey_down = 1'b0;
        if (key == 2)             nkey_step = 1'b0;
        repeat (hold) tick();
        nkey_up   = 1'b1;
        nkey_down = 1'b1;
        nkey_step = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        clk_en_i    = 1'b0;
        FSM_state   = 3'b000;
        nkey_up     = 1'b1;
        nkey_down   = 1'b1;
        nkey_step   = 1'b1;
        phase_off_i = '0;
        m_reset();
        repeat (3) tick();
        total++;
        if (addr_o !== 11'd0) begin
            bad++; $display("FAIL reset_addr: got %0d expected 0", addr_o);
        end
        total++;
        if (sync_o !== 1'b0) begin
            bad++; $display("FAIL reset_sync: got %0b expected 0", sync_o);
        end
        total++;
        if (ftw_o !== 32'd2097152) begin
            bad++; $display("FAIL reset_ftw: got %0d expected 2097152", ftw_o);
        end
        total++;
        if (step_idx_o !== 2'd0) begin
            bad++; $display("FAIL reset_step: got %0d expected 0", step_idx_o);
        end
        @(negedge clk_i);
        clk_en_i = 1'b1;
    endtask

    task automatic test_free_run();
        int syncs = 0;
        int exp_addr;
        bit exp_sync;
        for (int k = 1; k <= 4097; k++) begin
            tick();
            exp_addr = (k - 1) % 2048;
            exp_sync = (k >= 2049) && (exp_addr == 0);
            if (sync_o === 1'b1) syncs++;
            total++;
            if (addr_o !== 11'(exp_addr) || addr_o !== 11'(m_addr)) begin
                bad++; $display("FAIL run_addr k=%0d: got %0d expected %0d", k, addr_o, exp_addr);
            end
            total++;
            if (sync_o !== exp_sync || sync_o !== m_sync) begin
                bad++; $display("FAIL run_sync k=%0d: got %0b expected %0b", k, sync_o, exp_sync);
            end
        end
        total++;
        if (syncs != 2) begin
            bad++; $display("FAIL run_sync_count: got %0d expected 2", syncs);
        end
    endtask

    task automatic test_key_up_hold();
        FSM_state = 3'b010;
        repeat (2) tick();
        nkey_up = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            total++;
            if (ftw_o !== ((k < 3) ? 32'd2097152 : 32'd2162688) || ftw_o !== 32'(m_ftw)) begin
                bad++; $display("FAIL hold_up k=%0d: got %0d expected %0d", k, ftw_o,
                                (k < 3) ? 2097152 : 2162688);
            end
        end
        nkey_up = 1'b1;
        repeat (4) tick();
        press(2, 2);
        press(2, 2);
        total++;
        if (step_idx_o !== 2'd2 || step_idx_o !== 2'(m_step)) begin
            bad++; $display("FAIL step_two: got %0d expected 2", step_idx_o);
        end
        press(0, 3);
        total++;
        if (ftw_o !== 32'd3211264 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL up_step2: got %0d expected 3211264", ftw_o);
        end
    endtask

    task automatic test_saturation();
        press(2, 2);
        total++;
        if (step_idx_o !== 2'd3) begin
            bad++; $display("FAIL step_three: got %0d expected 3", step_idx_o);
        end
        repeat (300) press(0, 2);
        total++;
        if (ftw_o !== 32'h4000_0000 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL sat_max: got %0h expected 40000000", ftw_o);
        end
        repeat (300) press(1, 2);
        total++;
        if (ftw_o !== 32'd65536 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL sat_min_coarse: got %0d expected 65536", ftw_o);
        end
        press(2, 2);
        press(0, 2);
        total++;
        if (step_idx_o !== 2'd0 || ftw_o !== 32'd131072) begin
            bad++; $display("FAIL setup_131072: got step=%0d ftw=%0d expected step=0 ftw=131072",
                            step_idx_o, ftw_o);
        end
        press(1, 2);
        total++;
        if (ftw_o !== 32'd65536) begin
            bad++; $display("FAIL down_first: got %0d expected 65536", ftw_o);
        end
        press(1, 2);
        total++;
        if (ftw_o !== 32'd65536 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL down_floor: got %0d expected 65536", ftw_o);
        end
    endtask

    task automatic test_mode_gate();
        FSM_state = 3'b001;
        press(0, 3);
        total++;
        if (ftw_o !== 32'd65536) begin
            bad++; $display("FAIL gate_off: got %0d expected 65536", ftw_o);
        end
        nkey_up = 1'b0;
        repeat (5) tick();
        FSM_state = 3'b010;
        repeat (5) tick();
        total++;
        if (ftw_o !== 32'd65536 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL gate_no_queue: got %0d expected 65536", ftw_o);
        end
        nkey_up = 1'b1;
        repeat (4) tick();
        press(0, 3);
        total++;
        if (ftw_o !== 32'd131072 || ftw_o !== 32'(m_ftw)) begin
            bad++; $display("FAIL gate_on: got %0d expected 131072", ftw_o);
        end
    endtask

    task automatic test_simul_and_phase();
        int syncs = 0;
        press(3, 3);
        total++;
        if (ftw_o !== 32'd131072) begin
            bad++; $display("FAIL up_down_same: got %0d expected 131072", ftw_o);
        end
        repeat (3) press(2, 2);
        repeat (20) press(0, 2);
        total++;
        if (ftw_o !== 32'd84017152 || step_idx_o !== 2'd3) begin
            bad++; $display("FAIL phase_setup: got ftw=%0d step=%0d expected ftw=84017152 step=3",
                            ftw_o, step_idx_o);
        end
        phase_off_i = 11'd1024;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (sync_o === 1'b1) syncs++;
            total++;
            if (addr_o !== 11'(m_addr) || sync_o !== m_sync) begin
                bad++; $display("FAIL phase_off k=%0d: got addr=%0d sync=%0b expected addr=%0d sync=%0b",
                                k, addr_o, sync_o, m_addr, m_sync);
            end
        end
        total++;
        if (syncs < 10) begin
            bad++; $display("FAIL phase_sync_count: got %0d expected >=10", syncs);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) nkey_up   = ~nkey_up;
            if ($urandom_range(0, 5) == 0) nkey_down = ~nkey_down;
            if ($urandom_range(0, 5) == 0) nkey_step = ~nkey_step;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       FSM_state = 3'b000;
                    1:       FSM_state = 3'b001;
                    default: FSM_state = 3'b010;
                endcase
            end
            if ($urandom_range(0, 31) == 0) phase_off_i = 11'($urandom);
            tick();
            total++;
            if (addr_o !== 11'(m_addr) || sync_o !== m_sync ||
                ftw_o !== 32'(m_ftw) || step_idx_o !== 2'(m_step)) begin
                bad++;
                $display("FAIL rand k=%0d: got addr=%0d sync=%0b ftw=%0d step=%0d expected addr=%0d sync=%0b ftw=%0d step=%0d",
                         k, addr_o, sync_o, ftw_o, step_idx_o, m_addr, m_sync, m_ftw, m_step);
            end
        end
        nkey_up   = 1'b1;
        nkey_down = 1'b1;
        nkey_step = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        phase_off_i = '0;
        FSM_state   = 3'b000;
        repeat (37) tick();
        @(negedge clk_i);
        #2;
        clk_en_i = 1'b0;
        #1;
        m_reset();
        total++;
        if (addr_o !== 11'd0 || sync_o !== 1'b0 || ftw_o !== 32'd2097152 || step_idx_o !== 2'd0) begin
            bad++; $display("FAIL async_reset: got addr=%0d sync=%0b ftw=%0d step=%0d expected 0 0 2097152 0",
                            addr_o, sync_o, ftw_o, step_idx_o);
        end
        repeat (2) tick();
        @(negedge clk_i);
        clk_en_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (addr_o !== 11'(k - 1) || addr_o !== 11'(m_addr)) begin
                bad++; $display("FAIL restart_addr k=%0d: got %0d expected %0d", k, addr_o, k - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_key_up_hold();
        test_saturation();
        test_mode_gate();
        test_simul_and_phase();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
